read_cmd_block: RTL and testbench

- Upstream stage of the compare block in the memory checker.
- Accepts read-test commands as byte address + byte length, and issues one Avalon-MM read burst per command.
- For each accepted burst, emits the matching cmp_pkt_t (word address, word count, byte masks, data pattern) so the compare stage can check returning data.
- Limits outstanding bursts to what the compare stage can hold, and stops issuing after a reported mismatch.

---
 rtl/rtl_settings_pkg.sv | 51 +++++
 rtl/read_cmd_block_burst_track_fifo.sv | 93 +++++++++
 rtl/read_cmd_block.sv | 164 ++++++++++++++++
 tb/tb_read_cmd_block.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rtl_settings_pkg.sv
// ----------------------------------------------------------------------------
// rtl_settings_pkg
//   Shared settings for the memory checker read path: Avalon-MM geometry,
//   address interpretation, burst limits, the packet handed from the read
//   command block to the compare stage, and the read command FSM states.
//   Also holds the byte-mask helpers used when a command is converted to
//   a word-oriented burst.
// ----------------------------------------------------------------------------
package rtl_settings_pkg;

    localparam int    AMM_DATA_W = 32;                      // Avalon data width (bits)
    localparam int    ADDR_W     = 32;                      // command/Avalon address width
    localparam int    DATA_B_W   = AMM_DATA_W / 8;          // bytes per data word
    localparam int    ADDR_B_W   = $clog2(DATA_B_W);        // byte-in-word address bits
    localparam string ADDR_TYPE  = "BYTE";                  // "BYTE" or "WORD" Avalon addressing
    localparam int    MAX_BURST  = 8;                       // longest burst in words
    localparam int    BURST_W    = $clog2(MAX_BURST) + 1;   // Avalon burstcount width

    // Everything the compare stage needs to check one returning burst.
    typedef struct packed {
        logic [ADDR_W-1:0]   word_addr;
        logic [BURST_W-1:0]  word_count;
        logic [DATA_B_W-1:0] start_mask;     // valid bytes of the first word
        logic [DATA_B_W-1:0] end_mask;       // valid bytes of the last word
        logic [DATA_B_W-1:0] middle_mask;    // valid bytes when first == last word
        logic [7:0]          data_ptrn;
        logic                data_ptrn_mode; // 0 = fixed, 1 = LFSR
    } cmp_pkt_t;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        WAIT_SLOT,
        READ
    } read_cmd_state_t;

    // Bytes at or above the starting byte lane are valid in the first word.
    function automatic logic [DATA_B_W-1:0] start_mask_f(input logic [ADDR_B_W-1:0] s);
        logic [DATA_B_W-1:0] m;
        for (int i = 0; i < DATA_B_W; i++) m[i] = (i >= int'(s));
        return m;
    endfunction

    // Bytes at or below the ending byte lane are valid in the last word.
    function automatic logic [DATA_B_W-1:0] end_mask_f(input logic [ADDR_B_W-1:0] e);
        logic [DATA_B_W-1:0] m;
        for (int i = 0; i < DATA_B_W; i++) m[i] = (i <= int'(e));
        return m;
    endfunction

endpackage

// File: rtl/read_cmd_block_burst_track_fifo.sv
// ----------------------------------------------------------------------------
// burst_track_fifo
//   Tracks issued-but-incomplete read bursts. Holds the word count of each
//   burst in issue order; a beat counter runs down the head entry on every
//   returned beat and pops it on the last beat.
//
//   clk_i, rst_i   clock, asynchronous active-high reset
//   clear_i        drop all entries and the beat count (new test)
//   push_i         store push_data_i (word count of a burst just issued)
//   push_data_i    word count to store
//   beat_i         one read beat returned (Avalon readdatavalid)
//   pop_o          head burst completes this cycle
//   count_o        number of bursts currently outstanding
// ----------------------------------------------------------------------------
module burst_track_fifo #(
    parameter  int DEPTH  = 2,
    parameter  int DATA_W = 4,
    localparam int CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              push_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              beat_i,
    output logic              pop_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [CNT_W-1:0]  count;
    logic [DATA_W-1:0] beat_cnt;
    logic [DATA_W-1:0] beats_left;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (int'(p) == DEPTH - 1) ? '0 : p + PTR_W'(1);
    endfunction

    // A zero beat counter means "not yet loaded": the head entry is used
    // directly, so the first beat of a burst needs no extra load cycle.
    assign beats_left = (beat_cnt == '0) ? mem[rd_ptr] : beat_cnt;
    assign pop_o      = beat_i && (count != '0) && (beats_left == DATA_W'(1));
    assign count_o    = count;

    // NOTE: sequential state is assigned with <= so every flop samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // races between these registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            beat_cnt <= '0;
        end else if (clear_i) begin
            // A burst accepted in the same cycle as a clear is still in
            // flight, so it stays tracked as the only entry.
            rd_ptr   <= '0;
            wr_ptr   <= push_i ? next_ptr('0) : '0;
            count    <= push_i ? CNT_W'(1) : '0;
            beat_cnt <= '0;
        end else begin
            if (push_i) wr_ptr <= next_ptr(wr_ptr);

            if (pop_o) begin
                rd_ptr   <= next_ptr(rd_ptr);
                beat_cnt <= '0;
            end else if (beat_i && (count != '0)) begin
                beat_cnt <= beats_left - DATA_W'(1);
            end

            if (push_i && !pop_o)      count <= count + CNT_W'(1);
            else if (!push_i && pop_o) count <= count - CNT_W'(1);
        end
    end

    // NOTE: the storage array has no reset; an entry is only read after it
    // has been written, and leaving it out of reset keeps it plain RAM/flops
    // without a reset tree.
    always_ff @(posedge clk_i) begin
        if (push_i) mem[clear_i ? '0 : wr_ptr] <= push_data_i;
    end

    // A returned beat with nothing outstanding means the memory side and
    // this tracker disagree about what was issued.
    always @(posedge clk_i) begin
        if (!rst_i && !clear_i && beat_i) assert (count != '0);
    end

endmodule

// File: rtl/read_cmd_block.sv
// ----------------------------------------------------------------------------
// read_cmd_block
//   Turns byte-addressed read-test commands into Avalon-MM read bursts and
//   hands the compare stage a packet describing each burst. Limits bursts in
//   flight to MAX_OUTSTANDING and stops taking commands after a mismatch.
//
//   clk_i, rst_i          clock, asynchronous active-high reset
//   start_test_i          new test: clears stop flag and burst tracking
//   cmd_valid_i/ready_o   command handshake
//   cmd_addr_i, cmd_len_i start byte address, byte count
//   cmd_ptrn_i            initial data pattern byte
//   cmd_ptrn_mode_i       0 = fixed pattern, 1 = LFSR pattern
//   amm_*                 Avalon-MM read master (read, address, burstcount,
//                         waitrequest, readdatavalid)
//   err_check_i           mismatch pulse from the compare stage
//   cmp_pkt_en_o/cmp_pkt_o packet strobe and packet for the compare stage
//   busy_o                a command is held or bursts are outstanding
// ----------------------------------------------------------------------------
module read_cmd_block
    import rtl_settings_pkg::*;
#(
    parameter int MAX_OUTSTANDING = 2
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_test_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic [ADDR_W-1:0]  cmd_addr_i,
    input  logic [15:0]        cmd_len_i,
    input  logic [7:0]         cmd_ptrn_i,
    input  logic               cmd_ptrn_mode_i,
    output logic               amm_read_o,
    output logic [ADDR_W-1:0]  amm_address_o,
    output logic [BURST_W-1:0] amm_burstcount_o,
    input  logic               amm_waitrequest_i,
    input  logic               amm_readdatavalid_i,
    input  logic               err_check_i,
    output logic               cmp_pkt_en_o,
    output cmp_pkt_t           cmp_pkt_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam int WA_W  = ADDR_W - ADDR_B_W;   // word index width

    read_cmd_state_t state, state_nxt;

    logic [ADDR_W-1:0] cmd_addr_q;
    logic [15:0]       cmd_len_q;
    logic [7:0]        cmd_ptrn_q;
    logic              cmd_mode_q;
    cmp_pkt_t          pkt_q;
    cmp_pkt_t          calc_pkt;

    logic              stop_flg, stop_nxt;
    logic              ready_q;
    logic              busy_q;

    logic              cmd_accept;
    logic              amm_accept;
    logic              slot_free;
    logic              fifo_pop;
    logic [CNT_W-1:0]  fifo_count;

    logic [ADDR_W-1:0] end_addr;
    logic [WA_W-1:0]   wc_full;

    assign cmd_accept = cmd_valid_i && ready_q;
    assign amm_accept = (state == READ) && !amm_waitrequest_i;
    // A burst finishing this very cycle already frees its slot.
    assign slot_free  = (int'(fifo_count) - int'(fifo_pop)) < MAX_OUTSTANDING;
    assign stop_nxt   = start_test_i ? 1'b0 : (err_check_i ? 1'b1 : stop_flg);

    // Burst geometry; the end address may wrap around the address space.
    assign end_addr = cmd_addr_q + ADDR_W'(cmd_len_q) - ADDR_W'(1);
    assign wc_full  = end_addr[ADDR_W-1:ADDR_B_W] - cmd_addr_q[ADDR_W-1:ADDR_B_W] + WA_W'(1);

    always_comb begin
        calc_pkt = '0;
        if (ADDR_TYPE == "WORD")
            calc_pkt.word_addr = ADDR_W'(cmd_addr_q[ADDR_W-1:ADDR_B_W]);
        else
            calc_pkt.word_addr = {cmd_addr_q[ADDR_W-1:ADDR_B_W], {ADDR_B_W{1'b0}}};
        calc_pkt.word_count     = BURST_W'(wc_full);
        calc_pkt.start_mask     = start_mask_f(cmd_addr_q[ADDR_B_W-1:0]);
        calc_pkt.end_mask       = end_mask_f(end_addr[ADDR_B_W-1:0]);
        calc_pkt.middle_mask    = calc_pkt.start_mask & calc_pkt.end_mask;
        calc_pkt.data_ptrn      = cmd_ptrn_q;
        calc_pkt.data_ptrn_mode = cmd_mode_q;
    end

    // NOTE: every output of this block gets a default first so no path
    // leaves a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_nxt    = state;
        amm_read_o   = 1'b0;
        cmp_pkt_en_o = 1'b0;
        case (state)
            IDLE:      if (cmd_accept) state_nxt = CALC;
            CALC:      state_nxt = slot_free ? READ : WAIT_SLOT;
            WAIT_SLOT: if (slot_free) state_nxt = READ;
            READ: begin
                amm_read_o   = 1'b1;
                cmp_pkt_en_o = amm_accept;
                if (amm_accept) state_nxt = IDLE;
            end
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state    <= IDLE;
            stop_flg <= 1'b0;
            ready_q  <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            stop_flg <= stop_nxt;
            // Registered ready: high in IDLE unless stopped, so a mismatch
            // pulse drops it on the following cycle.
            ready_q  <= (state_nxt == IDLE) && !stop_nxt;
            busy_q   <= (state != IDLE) || (fifo_count != '0);
        end
    end

    // Command and packet registers are pure datapath, only read once the
    // FSM has loaded them.
    always_ff @(posedge clk_i) begin
        if (cmd_accept && (state == IDLE)) begin
            cmd_addr_q <= cmd_addr_i;
            cmd_len_q  <= cmd_len_i;
            cmd_ptrn_q <= cmd_ptrn_i;
            cmd_mode_q <= cmd_ptrn_mode_i;
        end
        if (state == CALC) pkt_q <= calc_pkt;
    end

    always @(posedge clk_i) begin
        if (!rst_i && (state == CALC)) assert (wc_full <= WA_W'(MAX_BURST));
    end

    burst_track_fifo #(
        .DEPTH  (MAX_OUTSTANDING),
        .DATA_W (BURST_W)
    ) u_track (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_test_i),
        .push_i      (amm_accept),
        .push_data_i (pkt_q.word_count),
        .beat_i      (amm_readdatavalid_i),
        .pop_o       (fifo_pop),
        .count_o     (fifo_count)
    );

    assign cmd_ready_o      = ready_q;
    assign busy_o           = busy_q;
    assign amm_address_o    = pkt_q.word_addr;
    assign amm_burstcount_o = pkt_q.word_count;
    assign cmp_pkt_o        = pkt_q;

endmodule

// File: tb/tb_read_cmd_block.sv
// ----------------------------------------------------------------------------
// tb_read_cmd_block
//   Directed bench for read_cmd_block with 4-byte words and byte addressing.
//   Inputs change 1 time unit after the rising edge; outputs are sampled at
//   that same point, well away from the active edge.
// ----------------------------------------------------------------------------
module tb_read_cmd_block;
    import rtl_settings_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start_test = 1'b0;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [ADDR_W-1:0]  cmd_addr = '0;
    logic [15:0]        cmd_len = '0;
    logic [7:0]         cmd_ptrn = '0;
    logic               cmd_mode = 1'b0;
    logic               amm_read;
    logic [ADDR_W-1:0]  amm_address;
    logic [BURST_W-1:0] amm_burstcount;
    logic               waitreq = 1'b0;
    logic               rdv = 1'b0;
    logic               err = 1'b0;
    logic               pkt_en;
    cmp_pkt_t           pkt;
    logic               busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    read_cmd_block #(.MAX_OUTSTANDING(2)) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_test_i        (start_test),
        .cmd_valid_i         (cmd_valid),
        .cmd_ready_o         (cmd_ready),
        .cmd_addr_i          (cmd_addr),
        .cmd_len_i           (cmd_len),
        .cmd_ptrn_i          (cmd_ptrn),
        .cmd_ptrn_mode_i     (cmd_mode),
        .amm_read_o          (amm_read),
        .amm_address_o       (amm_address),
        .amm_burstcount_o    (amm_burstcount),
        .amm_waitrequest_i   (waitreq),
        .amm_readdatavalid_i (rdv),
        .err_check_i         (err),
        .cmp_pkt_en_o        (pkt_en),
        .cmp_pkt_o           (pkt),
        .busy_o              (busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    endtask

    // Present a command and return one cycle after it is accepted (FSM in CALC).
    task automatic issue(input logic [ADDR_W-1:0] a, input logic [15:0] l,
                         input logic [7:0] p, input logic m);
        cmd_addr  = a;
        cmd_len   = l;
        cmd_ptrn  = p;
        cmd_mode  = m;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20 && !cmd_ready; k++) tick();
        check("cmd_ready_before_accept", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic beats(input int n);
        rdv = 1'b1;
        for (int k = 0; k < n; k++) tick();
        rdv = 1'b0;
    endtask

    initial begin
        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_cmd_ready", cmd_ready, 1'b0);
        check("rst_amm_read",  amm_read,  1'b0);
        check("rst_pkt_en",    pkt_en,    1'b0);
        check("rst_busy",      busy,      1'b0);
        rst = 1'b0;
        tick();
        check("post_rst_ready", cmd_ready, 1'b1);

        // ---------------- 1: single word, partial lanes ----------------
        issue(32'h102, 16'd2, 8'hA5, 1'b0);
        check("t1_calc_no_read", amm_read, 1'b0);
        tick();
        check("t1_read",        amm_read,        1'b1);
        check("t1_pkt_en",      pkt_en,          1'b1);
        check("t1_address",     amm_address,     32'h100);
        check("t1_burstcount",  amm_burstcount,  4'd1);
        check("t1_word_addr",   pkt.word_addr,   32'h100);
        check("t1_word_count",  pkt.word_count,  4'd1);
        check("t1_start_mask",  pkt.start_mask,  4'b1100);
        check("t1_end_mask",    pkt.end_mask,    4'b1111);
        check("t1_middle_mask", pkt.middle_mask, 4'b1100);
        check("t1_ptrn",        pkt.data_ptrn,   8'hA5);
        check("t1_mode",        pkt.data_ptrn_mode, 1'b0);
        tick();
        check("t1_pkt_en_off",  pkt_en,          1'b0);
        check("t1_read_off",    amm_read,        1'b0);
        check("t1_pkt_hold",    pkt.middle_mask, 4'b1100);
        check("t1_idle_ready",  cmd_ready,       1'b1);
        beats(1);

        // ---------------- 2: three words, unaligned both ends ----------------
        issue(32'h101, 16'd10, 8'h3C, 1'b1);
        tick();
        check("t2_pkt_en",      pkt_en,          1'b1);
        check("t2_address",     amm_address,     32'h100);
        check("t2_burstcount",  amm_burstcount,  4'd3);
        check("t2_word_count",  pkt.word_count,  4'd3);
        check("t2_start_mask",  pkt.start_mask,  4'b1110);
        check("t2_end_mask",    pkt.end_mask,    4'b0111);
        check("t2_middle_mask", pkt.middle_mask, 4'b0110);
        check("t2_ptrn",        pkt.data_ptrn,   8'h3C);
        check("t2_mode",        pkt.data_ptrn_mode, 1'b1);
        tick();
        beats(3);

        // ---------------- 3: waitrequest held for 5 cycles ----------------
        waitreq = 1'b1;
        issue(32'h204, 16'd4, 8'h11, 1'b0);
        tick();
        for (int k = 1; k <= 5; k++) begin
            check("t3_read_held",  amm_read,    1'b1);
            check("t3_addr_held",  amm_address, 32'h204);
            check("t3_no_pkt_en",  pkt_en,      1'b0);
            tick();
        end
        check("t3_busy", busy, 1'b1);
        waitreq = 1'b0;
        #1;
        check("t3_read_6th",   amm_read,       1'b1);
        check("t3_addr_6th",   amm_address,    32'h204);
        check("t3_burst_6th",  amm_burstcount, 4'd1);
        check("t3_pkt_en_6th", pkt_en,         1'b1);
        tick();
        check("t3_pkt_en_off", pkt_en,   1'b0);
        check("t3_read_off",   amm_read, 1'b0);
        beats(1);

        // ---------------- 4: outstanding limit ----------------
        issue(32'h300, 16'd16, 8'h01, 1'b0);
        tick();
        check("t4_a_read",  amm_read,       1'b1);
        check("t4_a_burst", amm_burstcount, 4'd4);
        tick();
        issue(32'h310, 16'd16, 8'h02, 1'b0);
        tick();
        check("t4_b_read", amm_read, 1'b1);
        tick();
        issue(32'h320, 16'd16, 8'h03, 1'b0);
        tick();
        check("t4_c_wait0", amm_read, 1'b0);
        tick();
        check("t4_c_wait1", amm_read, 1'b0);
        rdv = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            tick();
            check("t4_c_wait_beats", amm_read, 1'b0);
        end
        tick();
        rdv = 1'b0;
        check("t4_c_read",    amm_read,    1'b1);
        check("t4_c_address", amm_address, 32'h320);
        check("t4_c_pkt_en",  pkt_en,      1'b1);
        tick();
        beats(8);
        tick();
        tick();
        check("t4_drained_busy", busy, 1'b0);

        // ---------------- 5: mismatch stop and restart ----------------
        issue(32'h400, 16'd4, 8'h21, 1'b0);
        tick();
        check("t5_a_pkt_en", pkt_en, 1'b1);
        tick();
        issue(32'h404, 16'd4, 8'h22, 1'b0);
        err = 1'b1;
        tick();
        err = 1'b0;
        check("t5_b_read",    amm_read,    1'b1);
        check("t5_b_pkt_en",  pkt_en,      1'b1);
        check("t5_b_address", amm_address, 32'h404);
        check("t5_ready_low", cmd_ready,   1'b0);
        tick();
        check("t5_idle_ready_low", cmd_ready, 1'b0);
        cmd_valid = 1'b1;
        tick();
        check("t5_stopped_ready", cmd_ready, 1'b0);
        tick();
        check("t5_stopped_no_read", amm_read, 1'b0);
        cmd_valid  = 1'b0;
        start_test = 1'b1;
        err        = 1'b1;
        tick();
        start_test = 1'b0;
        err        = 1'b0;
        check("t5_restart_ready", cmd_ready, 1'b1);
        tick();
        check("t5_cleared_busy", busy, 1'b0);

        // ---------------- 6: reset during a stalled read ----------------
        waitreq = 1'b1;
        issue(32'h500, 16'd4, 8'h33, 1'b0);
        tick();
        check("t6_read",  amm_read, 1'b1);
        check("t6_busy",  busy,     1'b1);
        rst = 1'b1;
        #1;
        check("t6_rst_read",   amm_read,  1'b0);
        check("t6_rst_busy",   busy,      1'b0);
        check("t6_rst_pkt_en", pkt_en,    1'b0);
        check("t6_rst_ready",  cmd_ready, 1'b0);
        waitreq = 1'b0;
        #1;
        check("t6_rst_pkt_en_nowait", pkt_en, 1'b0);
        tick();
        rst = 1'b0;
        tick();
        check("t6_post_pkt_en", pkt_en,    1'b0);
        check("t6_post_read",   amm_read,  1'b0);
        check("t6_post_ready",  cmd_ready, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
